// File: rtl/filters_pkg.sv
// Shared definitions for the multi-channel FIR filter: filter-select codes,
// controller state encoding and an index-width helper.
package filters_pkg;

  typedef enum logic [1:0] {
    SEL_LPF = 2'b00,
    SEL_HPF = 2'b01,
    SEL_BPF = 2'b10,
    SEL_BYP = 2'b11
  } filt_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_LOAD,
    ST_MAC,
    ST_SCALE,
    ST_DONE
  } state_e;

  // Three coefficient banks (LPF, HPF, BPF); BYPASS has no bank.
  localparam int N_BANKS = 3;

  // Width of an index over n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Multiply-accumulate datapath with round-half-up, arithmetic shift and
// saturation back to the sample width.
module fir_mac
  import filters_pkg::*;
#(
  parameter int XW   = 16,
  parameter int CW   = 32,
  parameter int FRAC = 16,
  parameter int TAPS = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [XW-1:0] sample,
  input  logic signed [CW-1:0] coef,
  output logic signed [XW-1:0] result
);

  localparam int PW    = XW + CW;
  localparam int ACC_W = XW + CW + idx_w(TAPS);
  localparam int RW    = ACC_W + 1;
  localparam logic signed [RW-1:0] HALF   = RW'(1) << (FRAC - 1);
  localparam logic signed [RW-1:0] SAT_HI = RW'((longint'(1) << (XW - 1)) - 1);
  localparam logic signed [RW-1:0] SAT_LO = -SAT_HI - RW'(1);

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [RW-1:0]    rounded;
  logic signed [RW-1:0]    shifted;

  assign prod = PW'(sample) * PW'(coef);

  // Accumulator: cleared before each run, one product added per tap.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    if (rst || clr) acc <= '0;
    else if (en)    acc <= acc + ACC_W'(prod);
  end

  // Round half up, drop the fractional bits, clamp to the sample range.
  always_comb begin
    rounded = RW'(acc) + HALF;
    shifted = rounded >>> FRAC;
    if (shifted > SAT_HI)      result = SAT_HI[XW-1:0];
    else if (shifted < SAT_LO) result = SAT_LO[XW-1:0];
    else                       result = shifted[XW-1:0];
  end

endmodule

// File: rtl/filters_mc.sv
// Multi-channel FIR filter: per-channel circular sample history, three
// writable coefficient banks, one shared MAC that runs M taps per sample.
module filters_mc
  import filters_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int M               = 23,
  parameter int XADC_DATA_SIZE  = 16,
  parameter int XCOEF_DATA_SIZE = 32,
  parameter int COEF_FRAC       = 16,
  localparam int CHW = idx_w(N_CH),
  localparam int TW  = idx_w(M)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              filt_start,
  input  logic [1:0]                        filt_select,
  input  logic [CHW-1:0]                    filt_chan,
  input  logic signed [XADC_DATA_SIZE-1:0]  input_val,
  input  logic                              coef_we,
  input  logic [1:0]                        coef_bank,
  input  logic [TW-1:0]                     coef_addr,
  input  logic signed [XCOEF_DATA_SIZE-1:0] coef_data,
  output logic signed [XADC_DATA_SIZE-1:0]  filt_result,
  output logic [CHW-1:0]                    filt_chan_out,
  output logic                              filt_done,
  output logic                              filt_busy,
  output logic                              coef_err
);

  localparam int HW = idx_w(N_CH * M);

  state_e                              state, next_state;
  filt_sel_e                           sel_q;
  logic [CHW-1:0]                      chan_q;
  logic signed [XADC_DATA_SIZE-1:0]    sample_q;
  logic [TW-1:0]                       wptr [N_CH];
  logic [TW-1:0]                       rd_idx;
  logic [TW-1:0]                       tap;
  logic [HW-1:0]                       clr_cnt;
  logic [HW-1:0]                       load_addr;
  logic [HW-1:0]                       rd_addr;
  logic [1:0]                          bank_idx;
  logic                                coef_ok;
  logic signed [XADC_DATA_SIZE-1:0]    hist [N_CH * M];
  logic signed [XCOEF_DATA_SIZE-1:0]   coef_mem [N_BANKS][M];
  logic signed [XCOEF_DATA_SIZE-1:0]   mac_coef;
  logic signed [XADC_DATA_SIZE-1:0]    mac_result;

  assign filt_busy = (state != ST_IDLE);
  assign coef_ok   = (state == ST_IDLE) && (coef_bank != SEL_BYP);
  assign load_addr = HW'(chan_q) * HW'(M) + HW'(wptr[chan_q]);
  assign rd_addr   = HW'(chan_q) * HW'(M) + HW'(rd_idx);
  assign bank_idx  = sel_q;
  assign mac_coef  = (sel_q == SEL_BYP) ? '0 : coef_mem[bank_idx][tap];

  // State register; reset always starts the history-clearing sweep.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_CLR;
    else     state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch forms.
    next_state = state;
    unique case (state)
      ST_IDLE:  if (filt_start) next_state = ST_LOAD;
      ST_CLR:   if (clr_cnt == HW'(N_CH * M - 1)) next_state = ST_IDLE;
      ST_LOAD:  next_state = ST_MAC;
      ST_MAC:   if (tap == TW'(M - 1)) next_state = ST_SCALE;
      ST_SCALE: next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Run control: request capture, pointer/tap walking, result and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt       <= '0;
      sel_q         <= SEL_LPF;
      chan_q        <= '0;
      sample_q      <= '0;
      rd_idx        <= '0;
      tap           <= '0;
      filt_result   <= '0;
      filt_chan_out <= '0;
      filt_done     <= 1'b0;
      coef_err      <= 1'b0;
      for (int c = 0; c < N_CH; c++) wptr[c] <= '0;
    end else begin
      filt_done <= (state == ST_SCALE);
      coef_err  <= coef_we && !coef_ok;
      unique case (state)
        ST_CLR:  clr_cnt <= clr_cnt + 1'b1;
        ST_IDLE: if (filt_start) begin
          sel_q    <= filt_sel_e'(filt_select);
          chan_q   <= filt_chan;
          sample_q <= input_val;
        end
        ST_LOAD: begin
          // The newest sample sits at the old pointer; MAC walks backwards from it.
          rd_idx       <= wptr[chan_q];
          tap          <= '0;
          wptr[chan_q] <= (wptr[chan_q] == TW'(M - 1)) ? '0 : wptr[chan_q] + 1'b1;
        end
        ST_MAC: begin
          tap    <= tap + 1'b1;
          rd_idx <= (rd_idx == '0) ? TW'(M - 1) : rd_idx - 1'b1;
        end
        ST_SCALE: begin
          filt_result   <= (sel_q == SEL_BYP) ? sample_q : mac_result;
          filt_chan_out <= chan_q;
        end
        default: ;
      endcase
    end
  end

  // History storage: swept to zero in CLR, one sample written per run in LOAD.
  always_ff @(posedge clk) begin
    // NOTE: the history array has no reset branch; the CLR sweep zeroes it so
    // it can map onto plain RAM.
    if (state == ST_CLR)       hist[clr_cnt]   <= '0;
    else if (state == ST_LOAD) hist[load_addr] <= sample_q;
  end

  // Coefficient banks: writable only while idle, untouched by reset.
  always_ff @(posedge clk) begin
    if (coef_we && coef_ok && (coef_addr <= TW'(M - 1)))
      coef_mem[coef_bank][coef_addr] <= coef_data;
  end

  fir_mac #(
    .XW   (XADC_DATA_SIZE),
    .CW   (XCOEF_DATA_SIZE),
    .FRAC (COEF_FRAC),
    .TAPS (M)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == ST_LOAD),
    .en     (state == ST_MAC),
    .sample (hist[rd_addr]),
    .coef   (mac_coef),
    .result (mac_result)
  );

endmodule

// File: doc/filters_mc.md
FILTERS_MC -- requirements
Module: filters_mc

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent sample channels.
REQ-002 SHALL have parameter M, default 23: taps per filter.
REQ-003 SHALL have parameter XADC_DATA_SIZE, default 16: signed sample/result width.
REQ-004 SHALL have parameter XCOEF_DATA_SIZE, default 32: signed coefficient width.
REQ-005 SHALL have parameter COEF_FRAC, default 16: coefficient fractional bits; value 2^COEF_FRAC = 1.0.
REQ-006 SHALL have port clk  in  1: single clock; all logic on rising edge.
REQ-007 SHALL have port rst  in  1: reset, synchronous, active-high.
REQ-008 SHALL have port filt_start  in  1: one-cycle request to filter one sample.
REQ-009 SHALL have port filt_select  in  2: mode; 00 LPF, 01 HPF, 10 BPF, 11 BYPASS.
REQ-010 SHALL have port filt_chan  in  clog2(N_CH): target channel.
REQ-011 SHALL have port input_val  in  XADC_DATA_SIZE: new sample, two's complement.
REQ-012 SHALL have port coef_we  in  1: coefficient write strobe.
REQ-013 SHALL have port coef_bank  in  2: bank written (00 LPF, 01 HPF, 10 BPF; 11 ignored).
REQ-014 SHALL have port coef_addr  in  clog2(M): tap index.
REQ-015 SHALL have port coef_data  in  XCOEF_DATA_SIZE: coefficient value.
REQ-016 SHALL have port filt_result  out  XADC_DATA_SIZE: last filtered sample.
REQ-017 SHALL have port filt_chan_out  out  clog2(N_CH): channel of filt_result.
REQ-018 SHALL have port filt_done  out  1: one-cycle pulse, result valid.
REQ-019 SHALL have port filt_busy  out  1: high in every non-IDLE state.
REQ-020 SHALL have port coef_err  out  1: one-cycle pulse, coefficient write rejected.

Function
REQ-021 SHALL implement FSM IDLE, CLR, LOAD, MAC, SCALE, DONE.
REQ-022 SHALL, in IDLE with filt_start=1, capture filt_select, filt_chan, input_val and go to LOAD; filt_start outside IDLE is ignored.
REQ-023 SHALL, in LOAD, write the sample into history[filt_chan] at that channel's write pointer, advance the pointer modulo M, clear the accumulator, and go to MAC.
REQ-024 SHALL, in MAC, take exactly M cycles; tap k (k=0..M-1) multiplies coef[bank][k] by the sample k samples old (k=0 newest); history index wraps modulo M.
REQ-025 SHALL use an accumulator of XADC_DATA_SIZE+XCOEF_DATA_SIZE+clog2(M) bits; no intermediate overflow.
REQ-026 SHALL, in SCALE, add 2^(COEF_FRAC-1), arithmetic-shift right COEF_FRAC, saturate to [-2^(XADC_DATA_SIZE-1), 2^(XADC_DATA_SIZE-1)-1].
REQ-027 SHALL, in BYPASS mode, still update history and take identical latency, with result = captured input_val.
REQ-028 SHALL, in DONE, register filt_result and filt_chan_out, pulse filt_done for one cycle, and return to IDLE.
REQ-029 SHALL have fixed latency: start sampled at edge 0, filt_done high in cycle M+3; next start accepted the cycle after filt_done.
REQ-030 SHALL hold filt_result/filt_chan_out stable between done pulses.
REQ-031 SHALL accept coef_we only in IDLE with coef_bank != 11; otherwise discard and pulse coef_err the next cycle.
REQ-032 SHALL, when coef_we and filt_start coincide in IDLE, perform both; the write is visible to that filter run.
REQ-033 SHALL keep channels fully independent; a run on one channel leaves other channels' history and pointers unchanged.

Reset
REQ-034 SHALL, on rst, set filt_result=0, filt_chan_out=0, filt_done=0, coef_err=0, all write pointers=0, and enter CLR.
REQ-035 SHALL, in CLR, zero one history word per cycle over N_CH*M cycles with filt_busy=1, then enter IDLE.
REQ-036 SHALL abort any run on rst mid-operation with no filt_done pulse; coefficient banks are not affected by reset.

Structure
REQ-037 SHALL take filter-select codes, state encoding and width helpers from shared package filters_pkg.
REQ-038 SHALL place multiply-accumulate, rounding and saturation in sub-module fir_mac.

Verification
REQ-039 SHALL verify impulse: LPF coef[k]=65536*(k+1); ch0 input 100 then 22 zeros -> outputs 100,200,...,2300.
REQ-040 SHALL verify isolation: impulse on ch1 interleaved with zeros on ch0 -> ch0 all 0; ch1 matches REQ-039 sequence.
REQ-041 SHALL verify saturation: all coef 65536, input 32767 repeated -> output 32767 from second sample; input -32768 repeated -> -32768.
REQ-042 SHALL verify handshake: start while busy ignored; coef_we while busy -> coef_err pulse, coef unchanged; done exactly M+3 cycles after start.
REQ-043 SHALL verify reset mid-MAC: no filt_done, filt_busy high N_CH*M+1 cycles, then BYPASS input 5 -> 5 and LPF with history cleared -> 5*coef[0]/65536.
